// File: rtl/serial_alu_seq_if.sv
// Operation request / completion bundle for the bit-serial ALU sequencer.
// The master issues start/op/operands; the slave returns status and the result word.
interface serial_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             op_err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero, op_err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero, op_err
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds operands LSB-first through an external 1-bit
// ALU slice, one bit per cycle, and assembles the result word and status flags.
//
// state | meaning
// IDLE  | waiting for start; illegal op pulses op_err
// RUN   | WIDTH cycles, one operand bit per cycle through the slice
// DONE  | one-cycle completion, result and flags valid
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_alu_seq_if.slave     bus,
  output logic                slice_a,
  output logic                slice_b,
  output logic [2:0]          slice_op,
  output logic                slice_cin,
  output logic                slice_less,
  input  logic                slice_result,
  input  logic                slice_cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [2:0]       op_q;

  logic             run, is_arith, is_sub, last, ovf_nxt, op_legal;
  logic [WIDTH-1:0] sum_word, final_word;

  assign run      = (state == RUN);
  assign is_arith = op_q[1];
  assign is_sub   = op_q[2];
  assign last     = (cnt == CW'(WIDTH - 1));
  assign op_legal = (bus.op == 3'b000) || (bus.op == 3'b001) || (bus.op == 3'b010) ||
                    (bus.op == 3'b110) || (bus.op == 3'b111);

  // carry flop holds the carry into the current bit, i.e. into the MSB on the last cycle
  assign ovf_nxt    = is_arith & (carry ^ slice_cout);
  assign sum_word   = {slice_result, res_sh[WIDTH-1:1]};
  assign final_word = (op_q == 3'b111) ? {{(WIDTH-1){1'b0}}, slice_result ^ ovf_nxt} : sum_word;

  assign slice_a    = run & a_sh[0];
  assign slice_b    = run & b_sh[0];
  assign slice_cin  = run & carry;
  assign slice_op   = run ? (is_sub ? 3'b110 : op_q) : 3'b000;
  assign slice_less = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      res_sh        <= '0;
      cnt           <= '0;
      carry         <= 1'b0;
      op_q          <= 3'b000;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.op_err    <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      bus.op_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_legal) begin
              state    <= RUN;
              bus.busy <= 1'b1;
              a_sh     <= bus.a;
              b_sh     <= bus.b;
              res_sh   <= '0;
              cnt      <= '0;
              carry    <= bus.op[2];
              op_q     <= bus.op;
            end else begin
              bus.op_err <= 1'b1;
            end
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= sum_word;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.result    <= final_word;
            bus.carry_out <= is_arith & slice_cout;
            bus.overflow  <= ovf_nxt;
            bus.zero      <= (final_word == '0);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice.
module tb_serial_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       slice_a, slice_b, slice_cin, slice_less;
  logic [2:0] slice_op;
  logic       slice_result, slice_cout;
  int         checks = 0;
  int         errors = 0;

  serial_alu_seq_if #(.WIDTH(32)) bus ();

  serial_alu_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_op     (slice_op),
    .slice_cin    (slice_cin),
    .slice_less   (slice_less),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  always #5 clk = ~clk;

  // behavioural 1-bit slice: AND, OR, ADD, SUB (b inverted)
  always_comb begin
    logic bb;
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    bb           = slice_b;
    case (slice_op)
      3'b000: slice_result = slice_a & slice_b;
      3'b001: slice_result = slice_a | slice_b;
      3'b010, 3'b110: begin
        if (slice_op == 3'b110) bb = ~slice_b;
        slice_result = slice_a ^ bb ^ slice_cin;
        slice_cout   = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
      end
      default: ;
    endcase
  end

  // issue one operation and return the number of cycles until done is seen
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0; bus.op = 3'b001; bus.a = ~x; bus.b = ~y;
    end while (!bus.done && lat < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.op_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b done=%b op_err=%b exp 0 0 0", bus.busy, bus.done, bus.op_err); end
    checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status got result=%h z=%b c=%b v=%b exp 0", bus.result, bus.zero, bus.carry_out, bus.overflow); end
    checks++; if (slice_op !== 3'b000 || slice_a !== 1'b0 || slice_b !== 1'b0 || slice_cin !== 1'b0 || slice_less !== 1'b0) begin
      errors++; $display("FAIL reset_slice got op=%b a=%b b=%b cin=%b less=%b exp 0", slice_op, slice_a, slice_b, slice_cin, slice_less); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL add_latency got %0d exp 33", lat); end
    checks++; if (bus.result !== 32'h0 || bus.carry_out !== 1'b1 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL add_word got r=%h c=%b z=%b v=%b exp r=0 c=1 z=1 v=0", bus.result, bus.carry_out, bus.zero, bus.overflow); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy_done got %b exp 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse got done=%b busy=%b exp 0 0", bus.done, bus.busy); end
    checks++; if (bus.result !== 32'h0 || bus.carry_out !== 1'b1) begin
      errors++; $display("FAIL add_hold got r=%h c=%b exp 0 1", bus.result, bus.carry_out); end
  endtask

  task automatic test_slice();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h5; bus.b = 32'h7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    checks++; if (slice_op !== 3'b110 || slice_cin !== 1'b1 || slice_a !== 1'b1 || slice_b !== 1'b1) begin
      errors++; $display("FAIL slice_cycle0 got op=%b cin=%b a=%b b=%b exp 110 1 1 1", slice_op, slice_cin, slice_a, slice_b); end
    @(negedge clk);
    checks++; if (slice_a !== 1'b0 || slice_b !== 1'b1 || slice_cin !== 1'b1) begin
      errors++; $display("FAIL slice_cycle1 got a=%b b=%b cin=%b exp 0 1 1", slice_a, slice_b, slice_cin); end
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || bus.result !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL slice_result got done=%b r=%h exp 1 fffffffe", bus.done, bus.result); end
  endtask

  task automatic test_sub();
    int lat;
    run_op(3'b110, 32'h5, 32'h7, lat);
    checks++; if (lat !== 33 || bus.result !== 32'hFFFF_FFFE || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL sub_5_7 got lat=%0d r=%h c=%b v=%b z=%b exp 33 fffffffe 0 0 0", lat, bus.result, bus.carry_out, bus.overflow, bus.zero); end
    run_op(3'b110, 32'h8000_0000, 32'h1, lat);
    checks++; if (bus.result !== 32'h7FFF_FFFF || bus.overflow !== 1'b1 || bus.carry_out !== 1'b1) begin
      errors++; $display("FAIL sub_ovf got r=%h v=%b c=%b exp 7fffffff 1 1", bus.result, bus.overflow, bus.carry_out); end
  endtask

  task automatic test_slt();
    int lat;
    run_op(3'b111, 32'hFFFF_FFFF, 32'h1, lat);
    checks++; if (bus.result !== 32'h1 || bus.overflow !== 1'b0 || bus.carry_out !== 1'b1 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL slt_neg got r=%h v=%b c=%b z=%b exp 1 0 1 0", bus.result, bus.overflow, bus.carry_out, bus.zero); end
    run_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    checks++; if (bus.result !== 32'h0 || bus.overflow !== 1'b1 || bus.carry_out !== 1'b0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL slt_ovf got r=%h v=%b c=%b z=%b exp 0 1 0 1", bus.result, bus.overflow, bus.carry_out, bus.zero); end
  endtask

  task automatic test_logic();
    int lat;
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (bus.result !== 32'hF000_F000 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL and_word got r=%h c=%b v=%b exp f000f000 0 0", bus.result, bus.carry_out, bus.overflow); end
    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (bus.result !== 32'hFFF0_FFF0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL or_word got r=%h c=%b v=%b exp fff0fff0 0 0", bus.result, bus.carry_out, bus.overflow); end
  endtask

  task automatic test_op_err();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'h1; bus.b = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.op_err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL op_err_pulse got op_err=%b busy=%b exp 1 0", bus.op_err, bus.busy); end
    @(negedge clk);
    checks++; if (bus.op_err !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'hFFF0_FFF0) begin
      errors++; $display("FAIL op_err_hold got op_err=%b busy=%b r=%h exp 0 0 fff0fff0", bus.op_err, bus.busy, bus.result); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h1234; bus.b = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.result !== 32'h0 || slice_op !== 3'b000 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy=%b r=%h sop=%b done=%b exp 0 0 000 0", bus.busy, bus.result, slice_op, bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h3; bus.b = 32'h4;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_first_start got busy=%b exp 1", bus.busy); end
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || bus.result !== 32'h7 || n !== 32) begin
      errors++; $display("FAIL reset_after_op got done=%b r=%h n=%0d exp 1 7 32", bus.done, bus.result, n); end
  endtask

  task automatic test_busy_start();
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h10; bus.b = 32'h20;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bus.start = (i == 5 || i == 6) ? 1'b1 : 1'b0;
      bus.op = 3'b000; bus.a = 32'h0; bus.b = 32'h0;
      if (bus.done) dones++;
    end
    checks++; if (dones !== 1 || bus.result !== 32'h30) begin
      errors++; $display("FAIL busy_start got dones=%0d r=%h exp 1 00000030", dones, bus.result); end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    run_op(3'b010, 32'h5, 32'h6, lat);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h1; bus.b = 32'h1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'hB) begin
      errors++; $display("FAIL done_start_ignored got busy=%b done=%b r=%h exp 0 0 b", bus.busy, bus.done, bus.result); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL idle_start_accept got busy=%b exp 1", bus.busy); end
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || bus.result !== 32'h2 || n !== 32) begin
      errors++; $display("FAIL back_to_back got done=%b r=%h n=%0d exp 1 2 32", bus.done, bus.result, n); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_slice();
    test_sub();
    test_slt();
    test_logic();
    test_op_err();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits (legal range 2 to 64).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset; it is asynchronous and active-low.
REQ-004 start  in  1  SHALL request an operation; it is sampled only in IDLE.
REQ-005 op  in  3  SHALL select the operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are illegal.
REQ-006 a, b  in  WIDTH  SHALL be the operands, captured on the accepting edge.
REQ-007 slice_a, slice_b  out  1  SHALL be the current operand bits driven to the 1-bit ALU slice.
REQ-008 slice_op  out  3  SHALL be the slice operation code.
REQ-009 slice_cin  out  1  SHALL be the slice carry input.
REQ-010 slice_less  out  1  SHALL be the slice less input; it is constant 0.
REQ-011 slice_result, slice_cout  in  1  SHALL be the slice result bit and carry output.
REQ-012 busy  out  1  SHALL be high while an operation is in progress.
REQ-013 done  out  1  SHALL be a one-cycle completion pulse.
REQ-014 result  out  WIDTH  SHALL be the final word.
REQ-015 carry_out, overflow, zero, op_err  out  1  SHALL be the status flags.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start with a legal op.
- RUN->DONE after exactly WIDTH RUN cycles.
- DONE->IDLE unconditionally.
REQ-017 start with an illegal op in IDLE SHALL pulse op_err for one cycle, stay in IDLE, and leave result and flags unchanged.
REQ-018 The accepting edge SHALL load shift registers A=a, B=b, a bit counter of 0, and a carry flop: 1 for SUB/SLT, 0 otherwise.
REQ-019 In RUN cycle k (k=0..WIDTH-1):
- slice_a=A[k], slice_b=B[k], slice_cin=carry flop.
- slice_op = op for AND/OR/ADD, and 110 for SUB and SLT.
REQ-020 Each RUN edge SHALL:
- shift slice_result into the result shift register, LSB-first;
- load slice_cout into the carry flop;
- increment the counter.
REQ-021 Outside RUN, slice_a, slice_b and slice_cin SHALL be 0 and slice_op SHALL be 000.
REQ-022 On the last RUN edge (k=WIDTH-1), the block SHALL latch overflow = (carry into MSB) XOR slice_cout for ADD/SUB/SLT, and 0 for AND/OR.
REQ-023 carry_out SHALL be the final slice_cout for ADD/SUB/SLT and 0 for AND/OR.
REQ-024 For SLT, result SHALL be {WIDTH-1 zeros, (MSB of difference) XOR overflow}, and carry_out and overflow SHALL report the subtraction.
REQ-025 zero SHALL be 1 when the final result is all zeros.
REQ-026 result and all flags SHALL update together on the edge entering DONE and hold until the next accepted start.
REQ-027 busy SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-028 Latency: start accepted at edge E0 SHALL give done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after start.
REQ-029 start while busy SHALL be ignored and not queued.
REQ-030 start in the DONE cycle SHALL be ignored; a new start is accepted in the following IDLE cycle.
REQ-031 Operand and op inputs SHALL be don't-care after the accepting edge; changes SHALL NOT affect the operation in flight.

Reset
REQ-032 rst_n low SHALL immediately force the following, including mid-operation:
- state IDLE;
- busy=0, done=0, op_err=0;
- result=0, carry_out=0, overflow=0, zero=0;
- counter, shift registers and carry flop to 0.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 WIDTH=32, ADD a=FFFFFFFF, b=00000001 -> done 33 cycles after start; result=0, carry_out=1, zero=1, overflow=0.
REQ-035 SUB a=5, b=7 -> result=FFFFFFFE, carry_out=0, overflow=0, zero=0; SUB a=80000000, b=1 -> result=7FFFFFFF, overflow=1.
REQ-036 SLT a=FFFFFFFF, b=1 -> result=1; SLT a=7FFFFFFF, b=80000000 -> result=0 with overflow=1.
REQ-037 AND a=F0F0F0F0, b=FF00FF00 -> F000F000; OR on the same operands -> FFF0FFF0; carry_out=0, overflow=0.
REQ-038 op=011 with start -> op_err one-cycle pulse, busy stays 0, previous result is held.
REQ-039 Reset and busy handling:
- rst_n low at RUN cycle 10 -> busy=0 and result=0 immediately.
- start pulsed during RUN -> ignored; exactly one done pulse.
- The bench SHALL model the slice behaviourally per op codes 000/001/010/110.
